// File: rtl/box_draw_arbiter.sv
// Round-robin arbiter that hands boxes from several producers to one box drawer.
// Optional build macro: BOX_ARB_PRIORITY_EN (requester 0 takes precedence when unlocked).
module box_draw_arbiter #(
   parameter int NUM_REQ = 3
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     s_valid,
   input  logic [NUM_REQ-1:0]     s_last,
   input  logic [9*NUM_REQ-1:0]   s_box_x,
   input  logic [9*NUM_REQ-1:0]   s_box_y,
   input  logic [9*NUM_REQ-1:0]   s_box_w,
   input  logic [9*NUM_REQ-1:0]   s_box_h,
   input  logic [3*NUM_REQ-1:0]   s_box_color,
   output logic [NUM_REQ-1:0]     s_ready,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [8:0]             out_box_x,
   output logic [8:0]             out_box_y,
   output logic [8:0]             out_box_w,
   output logic [8:0]             out_box_h,
   output logic [2:0]             out_box_color,
   output logic                   locked
);

   // state  | meaning
   // S_IDLE | no box held; every cycle is an arbitration slot
   // S_BUSY | box held on out_box_*; a slot opens when the drawer takes it
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

   logic [0:0]        state;
   logic [IDX_W-1:0]  last_grant;
   logic [IDX_W-1:0]  lock_owner;
   logic              locked_q;

   logic              slot;
   logic              rr_found;
   logic [IDX_W-1:0]  rr_idx;
   logic              unl_found;
   logic [IDX_W-1:0]  unl_idx;
   logic              win_found;
   logic [IDX_W-1:0]  win_idx;
   logic              grant;

   assign slot = (state == S_IDLE) || m_ready;

   // Search starts just past the previous winner so every requester gets a turn.
   always_comb begin
      int unsigned       cand;
      logic [IDX_W-1:0]  cand_idx;
      rr_found = 1'b0;
      rr_idx   = '0;
      cand     = 0;
      cand_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand     = (int'(last_grant) + 1 + k) % NUM_REQ;
         cand_idx = IDX_W'(cand);
         if (!rr_found && s_valid[cand_idx]) begin
            rr_found = 1'b1;
            rr_idx   = cand_idx;
         end
      end
   end

`ifdef BOX_ARB_PRIORITY_EN
   // With bit 0 clear, the round-robin search already skips requester 0.
   assign unl_found = s_valid[0] | rr_found;
   assign unl_idx   = s_valid[0] ? '0 : rr_idx;
`else
   assign unl_found = rr_found;
   assign unl_idx   = rr_idx;
`endif

   always_comb begin
      win_found = unl_found;
      win_idx   = unl_idx;
      if (locked_q) begin
         win_found = s_valid[lock_owner];
         win_idx   = lock_owner;
      end
   end

   assign grant   = slot && win_found;
   assign s_ready = grant ? (ONE_HOT0 << win_idx) : '0;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         last_grant <= LAST_IDX;
         lock_owner <= '0;
         locked_q   <= 1'b0;
      end else if (slot) begin
         if (grant) begin
            state      <= S_BUSY;
            last_grant <= win_idx;
            if (s_last[win_idx]) begin
               locked_q <= 1'b0;
            end else begin
               locked_q   <= 1'b1;
               lock_owner <= win_idx;
            end
         end else begin
            state <= S_IDLE;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_box_x     <= 9'd0;
         out_box_y     <= 9'd0;
         out_box_w     <= 9'd1;
         out_box_h     <= 9'd1;
         out_box_color <= 3'd0;
      end else if (grant) begin
         out_box_x     <= s_box_x[9*win_idx +: 9];
         out_box_y     <= s_box_y[9*win_idx +: 9];
         out_box_w     <= s_box_w[9*win_idx +: 9];
         out_box_h     <= s_box_h[9*win_idx +: 9];
         out_box_color <= s_box_color[3*win_idx +: 3];
      end
   end

   assign m_valid = (state == S_BUSY);
   assign locked  = locked_q;

endmodule

// File: tb/tb_box_draw_arbiter.sv
// Directed bench for box_draw_arbiter: reset, single box, round-robin, burst lock,
// back-pressure and mid-transfer reset, with hand-computed expectations.
module tb_box_draw_arbiter;

   localparam int N = 3;

   logic            clock = 1'b0;
   logic            reset;
   logic [N-1:0]    s_valid;
   logic [N-1:0]    s_last;
   logic [9*N-1:0]  s_box_x, s_box_y, s_box_w, s_box_h;
   logic [3*N-1:0]  s_box_color;
   logic [N-1:0]    s_ready;
   logic            m_valid;
   logic            m_ready;
   logic [8:0]      out_box_x, out_box_y, out_box_w, out_box_h;
   logic [2:0]      out_box_color;
   logic            locked;

   int vectors = 0;
   int errors  = 0;

   box_draw_arbiter #(.NUM_REQ(N)) dut (
      .clock(clock), .reset(reset),
      .s_valid(s_valid), .s_last(s_last),
      .s_box_x(s_box_x), .s_box_y(s_box_y), .s_box_w(s_box_w), .s_box_h(s_box_h),
      .s_box_color(s_box_color), .s_ready(s_ready),
      .m_valid(m_valid), .m_ready(m_ready),
      .out_box_x(out_box_x), .out_box_y(out_box_y), .out_box_w(out_box_w),
      .out_box_h(out_box_h), .out_box_color(out_box_color), .locked(locked)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_box(input int i, input int x, input int y, input int w,
                          input int h, input int c);
      s_box_x[9*i +: 9]     = 9'(x);
      s_box_y[9*i +: 9]     = 9'(y);
      s_box_w[9*i +: 9]     = 9'(w);
      s_box_h[9*i +: 9]     = 9'(h);
      s_box_color[3*i +: 3] = 3'(c);
   endtask

   initial begin
      int rr_order [6];
      rr_order = '{0, 1, 2, 0, 1, 2};

      reset = 1'b1;
      s_valid = '0; s_last = '0; m_ready = 1'b0;
      s_box_x = '0; s_box_y = '0; s_box_w = '0; s_box_h = '0; s_box_color = '0;

      // reset values
      #12;
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_locked",  32'(locked),  32'd0);
      chk("rst_w",       32'(out_box_w), 32'd1);
      chk("rst_h",       32'(out_box_h), 32'd1);
      chk("rst_x",       32'(out_box_x), 32'd0);
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      tick();
      reset = 1'b0;
      tick();

      // single box from requester 1
      set_box(1, 5, 7, 10, 48, 3);
      s_valid = 3'b010; s_last = 3'b010;
      #1;
      chk("single_s_ready", 32'(s_ready), 32'b010);
      tick();
      s_valid = 3'b000;
      chk("single_m_valid", 32'(m_valid), 32'd1);
      chk("single_x", 32'(out_box_x), 32'd5);
      chk("single_y", 32'(out_box_y), 32'd7);
      chk("single_w", 32'(out_box_w), 32'd10);
      chk("single_h", 32'(out_box_h), 32'd48);
      chk("single_color", 32'(out_box_color), 32'd3);
      chk("single_locked", 32'(locked), 32'd0);
      m_ready = 1'b1;
      #1;
      chk("single_no_ready", 32'(s_ready), 32'd0);
      tick();
      chk("single_drain", 32'(m_valid), 32'd0);
      m_ready = 1'b0;

      // fresh reset so requester 0 is searched first, then round-robin with wrap
      reset = 1'b1;
      #2;
      reset = 1'b0;
      for (int i = 0; i < N; i++) set_box(i, 10 + i, 0, 1, 1, i);
      s_valid = 3'b111; s_last = 3'b111; m_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         #1;
         chk($sformatf("rr_s_ready_%0d", c), 32'(s_ready), 32'(1) << rr_order[c]);
         tick();
         chk($sformatf("rr_m_valid_%0d", c), 32'(m_valid), 32'd1);
         chk($sformatf("rr_x_%0d", c), 32'(out_box_x), 32'(10 + rr_order[c]));
      end
      s_valid = 3'b000;
      tick();
      chk("rr_drain", 32'(m_valid), 32'd0);

      // burst lock: requester 0 sends 4 boxes, requester 1 waits
      set_box(1, 30, 0, 1, 1, 1);
      set_box(0, 20, 0, 1, 1, 0);
      s_valid = 3'b011; s_last = 3'b010;
      #1;
      chk("burst0_s_ready", 32'(s_ready), 32'b001);
      tick();
      chk("burst0_x", 32'(out_box_x), 32'd20);
      chk("burst0_locked", 32'(locked), 32'd1);
      set_box(0, 21, 0, 1, 1, 0);
      #1;
      chk("burst1_s_ready", 32'(s_ready), 32'b001);
      tick();
      chk("burst1_x", 32'(out_box_x), 32'd21);
      s_valid = 3'b010;
      #1;
      chk("burst_stall_s_ready", 32'(s_ready), 32'b000);
      tick();
      chk("burst_stall_m_valid", 32'(m_valid), 32'd0);
      chk("burst_stall_locked", 32'(locked), 32'd1);
      set_box(0, 22, 0, 1, 1, 0);
      s_valid = 3'b011;
      #1;
      chk("burst2_s_ready", 32'(s_ready), 32'b001);
      tick();
      chk("burst2_x", 32'(out_box_x), 32'd22);
      set_box(0, 23, 0, 1, 1, 0);
      s_last = 3'b011;
      #1;
      chk("burst3_s_ready", 32'(s_ready), 32'b001);
      tick();
      chk("burst3_x", 32'(out_box_x), 32'd23);
      chk("burst3_unlocked", 32'(locked), 32'd0);
      s_valid = 3'b010;
      #1;
      chk("burst_r1_s_ready", 32'(s_ready), 32'b010);
      tick();
      chk("burst_r1_x", 32'(out_box_x), 32'd30);
      chk("burst_r1_locked", 32'(locked), 32'd0);
      s_valid = 3'b000;
      tick();
      chk("burst_drain", 32'(m_valid), 32'd0);
      m_ready = 1'b0;

      // back-pressure with requesters 0 and 2 valid (last grant was 1)
      set_box(0, 40, 0, 1, 1, 0);
      set_box(2, 42, 0, 1, 1, 2);
      s_valid = 3'b101; s_last = 3'b111;
      #1;
      chk("bp_first_s_ready", 32'(s_ready), 32'b100);
      tick();
      set_box(2, 44, 0, 1, 1, 2);
      for (int c = 0; c < 5; c++) begin
         #1;
         chk($sformatf("bp_s_ready_%0d", c), 32'(s_ready), 32'd0);
         chk($sformatf("bp_x_%0d", c), 32'(out_box_x), 32'd42);
         chk($sformatf("bp_m_valid_%0d", c), 32'(m_valid), 32'd1);
         tick();
      end
      m_ready = 1'b1;
      #1;
      chk("bp_release_s_ready", 32'(s_ready), 32'b001);
      tick();
      chk("bp_release_x", 32'(out_box_x), 32'd40);

      // lock requester 0, then reset mid-transfer
      set_box(0, 46, 0, 1, 1, 0);
      s_valid = 3'b001; s_last = 3'b110;
      #1;
      chk("mr_s_ready", 32'(s_ready), 32'b001);
      tick();
      chk("mr_m_valid", 32'(m_valid), 32'd1);
      chk("mr_locked", 32'(locked), 32'd1);
      s_valid = 3'b000;
      reset = 1'b1;
      #1;
      chk("mr_async_m_valid", 32'(m_valid), 32'd0);
      chk("mr_async_locked", 32'(locked), 32'd0);
      chk("mr_async_w", 32'(out_box_w), 32'd1);
      #2;
      reset = 1'b0;
      s_valid = 3'b111; s_last = 3'b111;
      #1;
      chk("mr_after_s_ready", 32'(s_ready), 32'b001);
      tick();
      chk("mr_after_x", 32'(out_box_x), 32'd46);
      chk("mr_after_locked", 32'(locked), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/box_draw_arbiter.md
# box_draw_arbiter

Shares the single box-drawer datapath between several box producers (frame screen drawer, score drawer, overlay drawer). Each requester offers one box per valid/ready transfer. The arbiter picks one requester round-robin, registers its box, and presents it to the box drawer on the same valid/ready protocol. A requester can lock the arbiter for a multi-box burst (for example, a background followed by paddles and ball) so that no other requester's box is drawn inside the burst.

## Interface
- NUM_REQ, 3, number of requesters; legal range 2..8; requester i occupies slice i of every packed bus.
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- s_valid  in  NUM_REQ  per-requester box offer.
- s_last  in  NUM_REQ  1 marks the final box of the requester's burst; 0 requests that the arbiter stay locked to this requester.
- s_box_x, s_box_y, s_box_w, s_box_h  in  9*NUM_REQ  per-requester box geometry; slice i is bits [9i+8:9i].
- s_box_color  in  3*NUM_REQ  per-requester box colour.
- s_ready  out  NUM_REQ  combinational, one-hot or zero; bit i high means requester i's box is captured this cycle.
- m_valid  out  1  registered; box presented to the drawer.
- m_ready  in  1  drawer accepts the presented box.
- out_box_x, out_box_y, out_box_w, out_box_h  out  9 each  registered box geometry.
- out_box_color  out  3  registered box colour.
- locked  out  1  registered; a burst is in progress.

## Operation
- The arbiter has two states: S_IDLE and S_BUSY. In S_BUSY, m_valid is 1 and the out_box_* registers hold the captured box.
- **Arbitration slot:** the arbiter evaluates a winner in a cycle when it is in S_IDLE, or when it is in S_BUSY with m_ready=1.
  - No other cycle evaluates a winner.
  - s_ready is 0 outside arbitration slots.
- **Unlocked winner selection:** the winner is the first set s_valid bit, searching from (last_grant+1) mod NUM_REQ upward with wrap-around.
- **Locked winner selection:** while locked=1, only lock_owner is eligible. If lock_owner is not valid, there is no winner and the other requesters stall. There is no timeout.
- **Capture (requester w wins):**
  - s_ready[w]=1.
  - Slice w of every s_box_* bus is registered into the out_box_* outputs.
  - The state becomes S_BUSY.
  - last_grant is set to w.
- **Lock update on capture:**
  - s_last[w]=0 sets locked=1 and lock_owner=w.
  - s_last[w]=1 sets locked=0.
- **No winner in a slot:**
  - From S_BUSY with m_ready=1, the state returns to S_IDLE and m_valid falls.
  - From S_IDLE, the state stays S_IDLE.
- **Reset values:**
  - State S_IDLE; m_valid=0; locked=0.
  - out_box_x, out_box_y, out_box_color all 0; out_box_w=out_box_h=1.
  - last_grant=NUM_REQ-1, so requester 0 is searched first; lock_owner=0.
- **Protocol rules for requesters:** a requester holds s_valid and its fields stable until s_ready. The arbiter does not check this. The drawer samples out_box_* only while m_valid=1.

## Timing
- **Capture-to-drawer latency:** a box captured in cycle N appears with m_valid=1 in cycle N+1.
- **Back-to-back:** a handoff with m_ready=1 and a pending winner keeps m_valid high continuously. Throughput is one box per cycle while the drawer is always ready.
- **Combinational paths:** s_ready depends combinationally on s_valid, m_ready, the state and the lock. There is no combinational path from any input to m_valid or to out_box_*.
- **Simultaneous requests:** exactly one requester is granted per cycle. Losers keep s_valid asserted and win within NUM_REQ-1 slots when unlocked.
- **Reset mid-transfer:**
  - Asserting reset drops m_valid and locked immediately, without waiting for a clock edge.
  - The in-flight box is discarded and is not re-presented.
  - Requesters re-offer their boxes after reset releases.
- **Wrap-around:** the round-robin pointer wraps from NUM_REQ-1 to 0.

## Configuration
- **BOX_ARB_PRIORITY_EN defined:** when unlocked, requester 0 wins whenever s_valid[0]=1, regardless of last_grant. The other requesters are served round-robin among themselves. This gives the frame screen drawer precedence so the refresh is never delayed by overlays. An existing lock is still honoured.
- **BOX_ARB_PRIORITY_EN undefined:** pure round-robin as specified under Operation.

## Test plan
- **Reset values:** assert reset with all inputs 0 -> m_valid=0, locked=0, out_box_w=1, out_box_h=1, s_ready=0.
- **Single box:** s_valid=3'b010, box (5,7,10,48,color 3), s_last=1 -> s_ready=3'b010 in cycle 0; m_valid=1 with out_box_x=5, out_box_y=7 in cycle 1; m_ready=1 in cycle 1 -> m_valid=0 in cycle 2.
- **Round-robin fairness:** s_valid=3'b111 held, all s_last=1, m_ready=1 constantly -> grant order 0,1,2,0,1,2 (without BOX_ARB_PRIORITY_EN), m_valid continuously high from cycle 1.
- **Burst lock:**
  - Stimulus: requester 0 sends 4 boxes with s_last=0,0,0,1 while requester 1 holds s_valid=1.
  - Required: requester 1 is granted only after requester 0's 4th box is captured, and locked falls in the cycle after that capture.
- **Back-pressure:** m_ready=0 for 5 cycles with two requesters valid -> out_box_* stable for all 5 cycles and s_ready=0 throughout.
- **Mid-transfer reset:** assert reset while m_valid=1 and locked=1 -> m_valid=0 and locked=0 immediately; after release, the next grant goes to requester 0.
